reset_button_monitor: RTL and testbench

Front-panel reset button monitor running on the 33 MHz main clock. It debounces the active-low reset button and classifies each press by duration. A short press drives a timed low pulse on `Reset1G`; a press held for 4 s drives a timed low pulse on `ResetOut_ox`. It is the source of the `Reset1G` and `ResetOut_ox` inputs consumed by the hardware reset generator in the control hierarchy, which forwards them to the 1G PHY and the PCH reset-button pin.

---
 rtl/reset_button_monitor.sv | 188 ++++++++++++++++++
 tb/tb_reset_button_monitor.sv | 123 ++++++++++++
 2 files changed

// File: rtl/reset_button_monitor.sv
`default_nettype none
// ============================================================================
// Module   : reset_button_monitor
// Purpose  : Debounces the front-panel reset button and turns short and long
//            presses into timed active-low pulses on Reset1G / ResetOut_ox.
// Config   : RSTBTN_SHORT_PRESS_1G_EN builds the short-press (Reset1G) path.
// Revision : 1.0 - initial release
// ============================================================================
module reset_button_monitor #(
  parameter int TICK_DIV    = 33000,
  parameter int DEBOUNCE_MS = 20,
  parameter int HOLD_MS     = 4000,
  parameter int PULSE_MS    = 100
) (
  input  logic MCLKi,
  input  logic RSTi,
  input  logic SYS_RSTBTN_N,
  input  logic FM_PS_EN,
  output logic ResetOut_ox,
  output logic Reset1G,
  output logic BtnPressed
);

  localparam logic [15:0] C_PRESC_LAST = 16'(TICK_DIV - 1);
  localparam logic [11:0] C_DEB_LAST   = 12'(DEBOUNCE_MS - 1);
  localparam logic [11:0] C_HOLD_LAST  = 12'(HOLD_MS - 1);
  localparam logic [11:0] C_PULSE_LAST = 12'(PULSE_MS - 1);
  localparam logic [11:0] C_TIMER_MAX  = 12'hFFF;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DEB_PRESS = 3'd1,
    S_HELD      = 3'd2,
`ifdef RSTBTN_SHORT_PRESS_1G_EN
    S_PULSE_1G  = 3'd3,
`endif
    S_PULSE_SYS = 3'd4,
    S_WAIT_REL  = 3'd5
  } state_t;

  logic        r_btn_s1;
  logic        r_btn_s2;
  logic        r_fm_s1;
  logic        r_fm_s2;
  state_t      r_state;
  logic [15:0] r_presc;
  logic [11:0] r_timer;
  logic        r_rst_sys_n;
  logic        r_rst_1g_n;
  logic        r_btn_pressed;

  logic        w_tick;
  logic        w_deb_hit;
  logic        w_hold_hit;
  logic        w_pulse_hit;

  always_ff @(posedge MCLKi or posedge RSTi) begin
    if (RSTi) begin
      r_btn_s1 <= 1'b1;
      r_btn_s2 <= 1'b1;
      r_fm_s1  <= 1'b0;
      r_fm_s2  <= 1'b0;
    end else begin
      r_btn_s1 <= SYS_RSTBTN_N;
      r_btn_s2 <= r_btn_s1;
      r_fm_s1  <= FM_PS_EN;
      r_fm_s2  <= r_fm_s1;
    end
  end

  // A "hit" fires on the tick that carries the timer up to its target, so a
  // state lasts exactly target x TICK_DIV cycles.
  assign w_tick      = (r_presc == C_PRESC_LAST);
  assign w_deb_hit   = w_tick && (r_timer == C_DEB_LAST);
  assign w_hold_hit  = w_tick && (r_timer == C_HOLD_LAST);
  assign w_pulse_hit = w_tick && (r_timer == C_PULSE_LAST);

  always_ff @(posedge MCLKi or posedge RSTi) begin
    if (RSTi) begin
      r_state       <= S_IDLE;
      r_presc       <= '0;
      r_timer       <= '0;
      r_rst_sys_n   <= 1'b1;
      r_rst_1g_n    <= 1'b1;
      r_btn_pressed <= 1'b0;
    end else if (!r_fm_s2) begin
      r_state       <= S_IDLE;
      r_presc       <= '0;
      r_timer       <= '0;
      r_rst_sys_n   <= 1'b1;
      r_rst_1g_n    <= 1'b1;
      r_btn_pressed <= 1'b0;
    end else begin
      if (w_tick) begin
        r_presc <= '0;
        if (r_timer != C_TIMER_MAX) r_timer <= r_timer + 12'd1;
      end else begin
        r_presc <= r_presc + 16'd1;
      end

      r_rst_sys_n   <= (r_state != S_PULSE_SYS);
`ifdef RSTBTN_SHORT_PRESS_1G_EN
      r_rst_1g_n    <= (r_state != S_PULSE_1G);
`else
      r_rst_1g_n    <= 1'b1;
`endif
      r_btn_pressed <= (r_state == S_HELD) || (r_state == S_PULSE_SYS);

      // Every transition below also restarts the prescaler and the ms timer.
      case (r_state)
        S_IDLE: begin
          if (!r_btn_s2) begin
            r_state <= S_DEB_PRESS;
            r_presc <= '0;
            r_timer <= '0;
          end
        end
        S_DEB_PRESS: begin
          if (r_btn_s2) begin
            r_state <= S_IDLE;
            r_presc <= '0;
            r_timer <= '0;
          end else if (w_deb_hit) begin
            r_state <= S_HELD;
            r_presc <= '0;
            r_timer <= '0;
          end
        end
        S_HELD: begin
          if (w_hold_hit) begin
            r_state <= S_PULSE_SYS;
            r_presc <= '0;
            r_timer <= '0;
          end else if (r_btn_s2) begin
`ifdef RSTBTN_SHORT_PRESS_1G_EN
            r_state <= S_PULSE_1G;
`else
            r_state <= S_WAIT_REL;
`endif
            r_presc <= '0;
            r_timer <= '0;
          end
        end
`ifdef RSTBTN_SHORT_PRESS_1G_EN
        S_PULSE_1G: begin
          if (w_pulse_hit) begin
            r_state <= S_WAIT_REL;
            r_presc <= '0;
            r_timer <= '0;
          end
        end
`endif
        S_PULSE_SYS: begin
          if (w_pulse_hit) begin
            r_state <= S_WAIT_REL;
            r_presc <= '0;
            r_timer <= '0;
          end
        end
        S_WAIT_REL: begin
          if (!r_btn_s2) begin
            r_presc <= '0;
            r_timer <= '0;
          end else if (w_deb_hit) begin
            r_state <= S_IDLE;
            r_presc <= '0;
            r_timer <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_presc <= '0;
          r_timer <= '0;
        end
      endcase
    end
  end

  assign ResetOut_ox = r_rst_sys_n;
  assign BtnPressed  = r_btn_pressed;
`ifdef RSTBTN_SHORT_PRESS_1G_EN
  assign Reset1G     = r_rst_1g_n;
`else
  assign Reset1G     = 1'b1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reset_button_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_reset_button_monitor
// Purpose  : Directed bench for reset_button_monitor with a small timebase
//            (TICK_DIV=4, DEBOUNCE_MS=2, HOLD_MS=10, PULSE_MS=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_reset_button_monitor;

  logic MCLKi = 1'b0;
  logic RSTi;
  logic SYS_RSTBTN_N;
  logic FM_PS_EN;
  logic ResetOut_ox;
  logic Reset1G;
  logic BtnPressed;

  int n_cmp = 0;
  int n_err = 0;
  int cur_k = 0;

  reset_button_monitor #(
    .TICK_DIV   (4),
    .DEBOUNCE_MS(2),
    .HOLD_MS    (10),
    .PULSE_MS   (3)
  ) dut (
    .MCLKi       (MCLKi),
    .RSTi        (RSTi),
    .SYS_RSTBTN_N(SYS_RSTBTN_N),
    .FM_PS_EN    (FM_PS_EN),
    .ResetOut_ox (ResetOut_ox),
    .Reset1G     (Reset1G),
    .BtnPressed  (BtnPressed)
  );

  always #5 MCLKi = ~MCLKi;

  task automatic step();
    @(posedge MCLKi);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s k=%0d: observed %b expected %b", tag, cur_k, obs, exp);
    end
  endtask

  // Press at edge 0, then for each edge k check the outputs against the
  // hand-derived low/high windows; release, power drop and reset are applied
  // after edge rel_k / fm_k / rst_k.
  task automatic scenario(input int n, input int rel_k, input int fm_k,
                          input int rst_k,
                          input int sys_lo, input int sys_hi,
                          input int g_lo, input int g_hi,
                          input int bp_lo, input int bp_hi);
    step();
    SYS_RSTBTN_N = 1'b0;
    for (int k = 1; k <= n; k++) begin
      step();
      cur_k = k;
      if (k == rst_k) begin
        RSTi = 1'b1;
        #1;
      end
      chk("ResetOut_ox", ResetOut_ox, !(k >= sys_lo && k <= sys_hi));
      chk("Reset1G",     Reset1G,     !(k >= g_lo && k <= g_hi));
      chk("BtnPressed",  BtnPressed,  (k >= bp_lo && k <= bp_hi));
      if (k == rel_k)     SYS_RSTBTN_N = 1'b1;
      if (k == fm_k)      FM_PS_EN = 1'b0;
      if (k == rst_k + 2) RSTi = 1'b0;
    end
  endtask

  initial begin
    RSTi         = 1'b1;
    SYS_RSTBTN_N = 1'b1;
    FM_PS_EN     = 1'b1;
    repeat (3) step();
    chk("reset ResetOut_ox", ResetOut_ox, 1'b1);
    chk("reset Reset1G",     Reset1G,     1'b1);
    chk("reset BtnPressed",  BtnPressed,  1'b0);
    RSTi = 1'b0;
    repeat (4) step();

    // bounce: 5-cycle glitch never completes debounce
    scenario(20, 5, -100, -100, 1, 0, 1, 0, 1, 0);

    // short press released after 20 cycles
`ifdef RSTBTN_SHORT_PRESS_1G_EN
    scenario(45, 20, -100, -100, 1, 0, 24, 35, 12, 23);
`else
    scenario(45, 20, -100, -100, 1, 0, 1, 0, 12, 23);
`endif

    // long press held 200 cycles: one pulse only
    scenario(215, 200, -100, -100, 52, 63, 1, 0, 12, 63);

    // power drop in the middle of the long-press pulse
    scenario(100, 70, 55, -100, 52, 57, 1, 0, 12, 57);
    // with power still off a long press is ignored
    scenario(80, 70, -100, -100, 1, 0, 1, 0, 1, 0);
    FM_PS_EN = 1'b1;
    repeat (5) step();

    // reset in the middle of the long-press pulse, button released with it
    scenario(80, 55, -100, 55, 52, 54, 1, 0, 12, 54);
    repeat (5) step();

`ifdef RSTBTN_SHORT_PRESS_1G_EN
    // reset in the middle of the short-press pulse
    scenario(60, 20, -100, 27, 1, 0, 24, 26, 12, 23);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
